// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core
// load/store unit (requester 0) and the loader/debug port (requester 1).
// It uses round-robin arbitration with one grant per cycle. It blocks
// out-of-range addresses from reaching the memory. It also tracks the
// memory's one-cycle read latency so each read result, or error pulse,
// returns to the requester that issued the access.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [31:0]       r0_addr,
    input  logic [DATA_W-1:0] r0_wrData,
    output logic              r0_gnt,
    output logic              r0_rdValid,
    output logic [DATA_W-1:0] r0_rdData,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [31:0]       r1_addr,
    input  logic [DATA_W-1:0] r1_wrData,
    output logic              r1_gnt,
    output logic              r1_rdValid,
    output logic [DATA_W-1:0] r1_rdData,
    output logic              r1_err,

    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wrData,
    output logic              mem_wrMem,
    output logic              mem_rdMem,
    input  logic [DATA_W-1:0] mem_rdData
);

    // Word-address bits the memory actually decodes.
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    // Round-robin pointer: port that received the most recent grant.
    logic              last;

    // Response owed next cycle for the access granted this cycle.
    logic              pend_valid;
    logic              pend_port;
    logic              pend_rd;
    logic              pend_err;

    // Request mux for the winning port.
    logic              any_gnt;
    logic              sel_port;
    logic              sel_wr;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wrData;
    logic              sel_in_range;

    // Grant decision: a lone requester wins; on conflict the port not granted last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (!rst) begin
            if (r0_req && r1_req) begin
                r0_gnt = last;
                r1_gnt = !last;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    // Select the granted port's access and check its address range.
    always_comb begin
        any_gnt      = r0_gnt || r1_gnt;
        sel_port     = r1_gnt;
        sel_wr       = r1_gnt ? r1_wr     : r0_wr;
        sel_addr     = r1_gnt ? r1_addr   : r0_addr;
        sel_wrData   = r1_gnt ? r1_wrData : r0_wrData;
        sel_in_range = (sel_addr >> ADDR_W) == 32'd0;
    end

    // Drive the memory command; idle and out-of-range cycles leave it all zero.
    always_comb begin
        mem_addr   = '0;
        mem_wrData = '0;
        mem_wrMem  = 1'b0;
        mem_rdMem  = 1'b0;
        if (any_gnt && sel_in_range) begin
            mem_addr   = sel_addr & ADDR_MASK;
            mem_wrData = sel_wrData;
            mem_wrMem  = sel_wr;
            mem_rdMem  = !sel_wr;
        end
    end

    // Advance the pointer on each grant and record the response owed next cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            last       <= 1'b1;
            pend_valid <= 1'b0;
            pend_port  <= 1'b0;
            pend_rd    <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            pend_valid <= any_gnt;
            if (any_gnt) begin
                last      <= sel_port;
                pend_port <= sel_port;
                pend_rd   <= !sel_wr;
                pend_err  <= !sel_in_range;
            end
        end
    end

    // Route the pending response to its owner; everything is masked during reset.
    always_comb begin
        r0_rdValid = 1'b0;
        r1_rdValid = 1'b0;
        r0_err     = 1'b0;
        r1_err     = 1'b0;
        r0_rdData  = '0;
        r1_rdData  = '0;
        if (!rst && pend_valid) begin
            if (pend_port) begin
                r1_rdValid = pend_rd;
                r1_err     = pend_err;
                if (pend_rd && !pend_err) begin
                    r1_rdData = mem_rdData;
                end
            end else begin
                r0_rdValid = pend_rd;
                r0_err     = pend_err;
                if (pend_rd && !pend_err) begin
                    r0_rdData = mem_rdData;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. It provides a
// 1024-word memory with a registered read. A transaction-level reference
// model predicts the grants, the memory commands and the routed responses.
// Directed scenarios are followed by randomized traffic with occasional
// resets.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_wr, r1_req, r1_wr;
    logic [31:0] r0_addr, r0_wrData, r1_addr, r1_wrData;
    logic        r0_gnt, r0_rdValid, r0_err, r1_gnt, r1_rdValid, r1_err;
    logic [31:0] r0_rdData, r1_rdData;
    logic [31:0] mem_addr, mem_wrData, mem_rdData;
    logic        mem_wrMem, mem_rdMem;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wrData(r0_wrData),
        .r0_gnt(r0_gnt), .r0_rdValid(r0_rdValid), .r0_rdData(r0_rdData), .r0_err(r0_err),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wrData(r1_wrData),
        .r1_gnt(r1_gnt), .r1_rdValid(r1_rdValid), .r1_rdData(r1_rdData), .r1_err(r1_err),
        .mem_addr(mem_addr), .mem_wrData(mem_wrData), .mem_wrMem(mem_wrMem),
        .mem_rdMem(mem_rdMem), .mem_rdData(mem_rdData)
    );

    always #5 clk = ~clk;

    // Data memory with a registered read port; clr wipes it at start-up.
    logic [31:0] emem [1024];
    logic        clr;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) emem[i] <= '0;
            mem_rdData <= '0;
        end else begin
            if (mem_wrMem) emem[mem_addr[9:0]] <= mem_wrData;
            if (mem_rdMem) mem_rdData <= emem[mem_addr[9:0]];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [1024];
    bit          m_last;              // port granted most recently
    bit          e_valid, e_port, e_rd, e_err;
    logic [31:0] e_data;
    bit          g_any, g_win;        // model grant for the cycle just stepped
    logic        obs_g0, obs_g1, obs_wrMem, obs_rdMem;

    typedef struct {
        bit          act;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t rq [2];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input bit req, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (p == 0) begin
            r0_req = req; r0_wr = wr; r0_addr = addr; r0_wrData = data;
        end else begin
            r1_req = req; r1_wr = wr; r1_addr = addr; r1_wrData = data;
        end
    endtask

    // Called at posedge+1 with this cycle's inputs already driven: checks every
    // output against the model, advances the model and returns at the next posedge+1.
    task automatic step();
        bit          any, win, wr, inr;
        logic [31:0] a, d;
        bit          x_rv0, x_rv1, x_er0, x_er1;
        logic [31:0] x_rd0, x_rd1;
        #1;
        x_rv0 = !rst && e_valid && !e_port && e_rd;
        x_rv1 = !rst && e_valid &&  e_port && e_rd;
        x_er0 = !rst && e_valid && !e_port && e_err;
        x_er1 = !rst && e_valid &&  e_port && e_err;
        x_rd0 = (x_rv0 && !e_err) ? e_data : 32'd0;
        x_rd1 = (x_rv1 && !e_err) ? e_data : 32'd0;

        any = 1'b0;
        win = 1'b0;
        if (!rst) begin
            if (r0_req && r1_req) begin
                any = 1'b1;
                win = (m_last == 1'b1) ? 1'b0 : 1'b1;
            end else if (r0_req) begin
                any = 1'b1;
            end else if (r1_req) begin
                any = 1'b1;
                win = 1'b1;
            end
        end
        wr  = win ? r1_wr : r0_wr;
        a   = win ? r1_addr : r0_addr;
        d   = win ? r1_wrData : r0_wrData;
        inr = a < 32'd1024;

        obs_g0 = r0_gnt; obs_g1 = r1_gnt; obs_wrMem = mem_wrMem; obs_rdMem = mem_rdMem;
        check_eq("r0_gnt", r0_gnt, any && !win);
        check_eq("r1_gnt", r1_gnt, any && win);
        check_eq("mem_wrMem", mem_wrMem, any && inr && wr);
        check_eq("mem_rdMem", mem_rdMem, any && inr && !wr);
        if (!any) begin
            check_eq("mem_addr_idle", mem_addr, 32'd0);
            check_eq("mem_wrData_idle", mem_wrData, 32'd0);
        end else if (inr) begin
            check_eq("mem_addr", mem_addr, a);
            check_eq("mem_wrData", mem_wrData, d);
        end
        check_eq("r0_rdValid", r0_rdValid, x_rv0);
        check_eq("r1_rdValid", r1_rdValid, x_rv1);
        check_eq("r0_err", r0_err, x_er0);
        check_eq("r1_err", r1_err, x_er1);
        check_eq("r0_rdData", r0_rdData, x_rd0);
        check_eq("r1_rdData", r1_rdData, x_rd1);

        if (rst) begin
            m_last  = 1'b1;
            e_valid = 1'b0;
        end else begin
            e_valid = any;
            if (any) begin
                e_port = win;
                e_rd   = !wr;
                e_err  = !inr;
                e_data = (inr && !wr) ? ref_mem[a[9:0]] : 32'd0;
                if (inr && wr) ref_mem[a[9:0]] = d;
                m_last = win;
            end
        end
        g_any = any;
        g_win = win;
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t new_txn();
        txn_t t;
        t.act  = $urandom_range(0, 3) != 0;
        t.wr   = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 9) == 0) t.addr = $urandom | 32'h400;
        else                           t.addr = 32'($urandom_range(0, 15));
        t.data = $urandom;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        m_last = 1'b1; e_valid = 1'b0; e_port = 1'b0; e_rd = 1'b0; e_err = 1'b0; e_data = '0;
        rst = 1'b1; clr = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Requests held through reset are never granted; first release cycle grants
        drive(0, 1, 1, 32'd3, 32'hDEAD);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_gnt0", obs_g0, 1'b0);
            check_eq("rst_wrMem", obs_wrMem, 1'b0);
        end
        rst = 1'b0;
        step();
        check_eq("release_gnt0", obs_g0, 1'b1);

        // Write then read the same address back to back
        drive(0, 1, 1, 32'd5, 32'h00001234);
        step();
        check_eq("wr5_gnt", obs_g0, 1'b1);
        drive(0, 1, 0, 32'd5, 32'd0);
        step();
        check_eq("rd5_gnt", obs_g0, 1'b1);
        drive(0, 0, 0, 32'd0, 32'd0);
        check_eq("rd5_valid", r0_rdValid, 1'b1);
        check_eq("rd5_data", r0_rdData, 32'h00001234);
        check_eq("rd5_p1_valid", r1_rdValid, 1'b0);
        step();

        // Preload through port 1, leaving the pointer on port 1
        drive(1, 1, 1, 32'd1, 32'hA);
        step();
        drive(1, 1, 1, 32'd2, 32'hB);
        step();

        // Continuous contention alternates grants, starting with port 0
        drive(0, 1, 0, 32'd1, 32'd0);
        drive(1, 1, 0, 32'd2, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("alt_gnt0", obs_g0, (i % 2) == 0);
            check_eq("alt_gnt1", obs_g1, (i % 2) == 1);
            if (r0_rdValid) check_eq("alt_data0", r0_rdData, 32'hA);
            if (r1_rdValid) check_eq("alt_data1", r1_rdData, 32'hB);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step();

        // Out-of-range read and write on port 1
        drive(1, 1, 0, 32'h400, 32'd0);
        step();
        check_eq("oor_rd_gnt", obs_g1, 1'b1);
        check_eq("oor_rd_rdMem", obs_rdMem, 1'b0);
        drive(1, 1, 1, 32'hFFFFFFFF, 32'h77);
        check_eq("oor_rd_valid", r1_rdValid, 1'b1);
        check_eq("oor_rd_data", r1_rdData, 32'd0);
        check_eq("oor_rd_err", r1_err, 1'b1);
        step();
        check_eq("oor_wr_wrMem", obs_wrMem, 1'b0);
        drive(1, 0, 0, 0, 0);
        check_eq("oor_wr_err", r1_err, 1'b1);
        check_eq("oor_wr_valid", r1_rdValid, 1'b0);
        step();

        // Point last at port 0, then port 1's write beats port 0's read
        drive(0, 1, 1, 32'd9, 32'h99);
        step();
        drive(0, 1, 0, 32'd7, 32'd0);
        drive(1, 1, 1, 32'd7, 32'h55);
        step();
        check_eq("fav1_gnt1", obs_g1, 1'b1);
        drive(1, 0, 0, 0, 0);
        step();
        check_eq("fav1_gnt0", obs_g0, 1'b1);
        drive(0, 0, 0, 0, 0);
        check_eq("fav1_data", r0_rdData, 32'h55);
        step();

        // Reset right after a read grant discards its response
        drive(0, 1, 0, 32'd7, 32'd0);
        step();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstmid_valid", r0_rdValid, 1'b0);
        drive(0, 1, 0, 32'd1, 32'd0);
        drive(1, 1, 0, 32'd2, 32'd0);
        step();
        check_eq("post_rst_gnt0", obs_g0, 1'b1);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step();

        // Randomized traffic; requesters hold until granted, occasional resets
        rq[0] = new_txn();
        rq[1] = new_txn();
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < 2; p++) drive(p, rq[p].act, rq[p].wr, rq[p].addr, rq[p].data);
            rst = ($urandom_range(0, 49) == 0);
            step();
            if (g_any) rq[g_win] = new_txn();
            for (int p = 0; p < 2; p++) if (!rq[p].act) rq[p] = new_txn();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
